mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 118 +++++++++++
 tb/tb_mdu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Execute-stage to MDU signal bundle: operation issue, operands and HI/LO results.
interface mdu_ctrl_if;
    logic [3:0]  e_op;
    logic        e_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mfx_data;

    modport master (
        output e_op, e_valid, rs_val, rt_val, d_is_md,
        input  busy, stall, hi, lo, mfx_data
    );

    modport slave (
        input  e_op, e_valid, rs_val, rt_val, d_is_md,
        output busy, stall, hi, lo, mfx_data
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: the result is computed at issue, held pending,
// and committed to HI/LO when the fixed busy window expires.
module mdu_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave mdu
);
    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi_q, pend_lo_q;
    logic             pend_ok_q;

    logic [3:0]       op;
    logic             is_mul;
    logic             start;
    logic [63:0]      res_d;
    logic             ok_d;

    function automatic logic [63:0] mul_res(input logic uns, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = uns ? {32'd0, a} : {{32{a[31]}}, a};
        sb = uns ? {32'd0, b} : {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] div_res(input logic uns, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] ma, mb, uq, ur;
        logic        na, nb;
        na = !uns && a[31];
        nb = !uns && b[31];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        if (mb == 32'd0) return 64'd0;
        uq = ma / mb;
        ur = ma % mb;
        return {(na ? -ur : ur), ((na ^ nb) ? -uq : uq)};
    endfunction

    always_comb begin
        op = OP_NONE;
        if (mdu.e_valid && mdu.e_op <= OP_MTLO) op = mdu.e_op;
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        start  = (state_q == IDLE) && (op >= OP_MULT) && (op <= OP_DIVU);
        res_d  = is_mul ? mul_res(op == OP_MULTU, mdu.rs_val, mdu.rt_val)
                        : div_res(op == OP_DIVU, mdu.rs_val, mdu.rt_val);
        ok_d   = is_mul || (mdu.rt_val != 32'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= is_mul ? MUL : DIV;
                        cnt_q     <= is_mul ? CNT_W'(MUL_CYC) : CNT_W'(DIV_CYC);
                        busy_q    <= 1'b1;
                        pend_hi_q <= res_d[63:32];
                        pend_lo_q <= res_d[31:0];
                        pend_ok_q <= ok_d;
                    end else if (op == OP_MTHI) begin
                        hi_q <= mdu.rs_val;
                    end else if (op == OP_MTLO) begin
                        lo_q <= mdu.rs_val;
                    end
                end
                default: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (pend_ok_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end
                end
            endcase
        end
    end

    assign mdu.busy     = busy_q;
    assign mdu.stall    = mdu.d_is_md & (busy_q | start);
    assign mdu.hi       = hi_q;
    assign mdu.lo       = lo_q;
    assign mdu.mfx_data = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_mdu_ctrl;
    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 10;

    logic clk = 1'b0;
    logic reset;
    mdu_ctrl_if bus();

    mdu_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk  (clk),
        .reset(reset),
        .mdu  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: architectural HI/LO, a pending result and the number of busy cycles left.
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    bit          m_pok = 0;
    int          m_left = 0;

    function automatic logic [63:0] ref_result(input int code, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, up, res;
        res = 64'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (code)
            1: begin sq = sa * sb; res = sq; end
            2: begin up = ua * ub; res = up; end
            3: if (b != 0) begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
            4: if (b != 0) res = {a % b, a / b};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic int eff_op();
        if (!bus.e_valid || bus.e_op > 4'd8) return 0;
        return int'(bus.e_op);
    endfunction

    function automatic bit exp_busy();
        return m_left > 0;
    endfunction

    function automatic bit exp_stall();
        int o;
        o = eff_op();
        return bus.d_is_md && (m_left > 0 || (o >= 1 && o <= 4));
    endfunction

    function automatic logic [31:0] exp_mfx();
        int o;
        o = eff_op();
        return (o == 5) ? m_hi : (o == 6) ? m_lo : 32'd0;
    endfunction

    task automatic model_edge();
        int o;
        logic [63:0] r;
        o = eff_op();
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (o >= 1 && o <= 4) begin
            m_left = (o <= 2) ? MUL_CYC : DIV_CYC;
            r = ref_result(o, bus.rs_val, bus.rt_val);
            m_phi = r[63:32];
            m_plo = r[31:0];
            m_pok = (o <= 2) || (bus.rt_val != 0);
        end else if (o == 7) begin
            m_hi = bus.rs_val;
        end else if (o == 8) begin
            m_lo = bus.rs_val;
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
    endtask

    task automatic drive(input logic [3:0] op, input logic v, input logic [31:0] rs,
                         input logic [31:0] rt, input logic dmd);
        bus.e_op = op; bus.e_valid = v; bus.rs_val = rs; bus.rt_val = rt; bus.d_is_md = dmd;
        #1;
    endtask

    task automatic tick();
        if (reset) model_edge();
        @(posedge clk);
        #1;
    endtask

    // Runs until busy drops (bounded) and returns the number of busy cycles seen.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(4'd5, 1'b1, 32'h0, 32'h0, 1'b0);
        #20;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
        total++; if (bus.mfx_data !== 32'd0) begin bad++; $display("FAIL reset_mfx got=%h want=0", bus.mfx_data); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_mul();
        int n;
        drive(4'd2, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        tick();
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL multu_hi_early got=%h want=0", bus.hi); end
        wait_idle(n);
        total++; if (n != MUL_CYC) begin bad++; $display("FAIL multu_busy got=%0d want=%0d", n, MUL_CYC); end
        total++; if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL multu_res got=%h_%h want=00000001_fffffffe", bus.hi, bus.lo); end
        drive(4'd1, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        tick();
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle(n);
        total++; if (n != MUL_CYC) begin bad++; $display("FAIL mult_busy got=%0d want=%0d", n, MUL_CYC); end
        total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL mult_res got=%h_%h want=ffffffff_fffffffe", bus.hi, bus.lo); end
    endtask

    task automatic test_div();
        int n;
        drive(4'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        tick();
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle(n);
        total++; if (n != DIV_CYC) begin bad++; $display("FAIL div_busy got=%0d want=%0d", n, DIV_CYC); end
        total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL div_res got=%h_%h want=ffffffff_fffffffd", bus.hi, bus.lo); end
        drive(4'd4, 1'b1, 32'd7, 32'd0, 1'b0);
        tick();
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle(n);
        total++; if (n != DIV_CYC) begin bad++; $display("FAIL divu0_busy got=%0d want=%0d", n, DIV_CYC); end
        total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL divu0_keep got=%h_%h want=ffffffff_fffffffd", bus.hi, bus.lo); end
    endtask

    task automatic test_stall();
        drive(4'd1, 1'b1, 32'd3, 32'd5, 1'b1);
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL stall_start got=%b want=1", bus.stall); end
        tick();
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < MUL_CYC; i++) begin
            total++; if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL stall_busy cyc=%0d got=%b/%b want=1/1", i, bus.stall, bus.busy); end
            tick();
        end
        total++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL stall_idle got=%b/%b want=0/0", bus.stall, bus.busy); end
        total++; if (bus.lo !== 32'd15) begin bad++; $display("FAIL stall_res got=%h want=f", bus.lo); end
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [63:0] want;
        want = ref_result(2, 32'h9ABC_DEF0, 32'h1357_9BDF);
        drive(4'd2, 1'b1, 32'h9ABC_DEF0, 32'h1357_9BDF, 1'b0);
        tick();
        for (int i = 0; i < MUL_CYC - 1; i++) begin
            drive(4'd3, 1'b1, $urandom, $urandom | 32'd1, 1'b0);
            tick();
        end
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle(n);
        total++; if (n != 1) begin bad++; $display("FAIL ignore_busy_tail got=%0d want=1", n); end
        total++; if ({bus.hi, bus.lo} !== want) begin
            bad++; $display("FAIL ignore_res got=%h_%h want=%h", bus.hi, bus.lo, want); end
    endtask

    task automatic test_mtx();
        int n;
        drive(4'd7, 1'b1, 32'h0000_1234, 32'h0, 1'b0);
        tick();
        drive(4'd5, 1'b1, 32'h0, 32'h0, 1'b0);
        total++; if (bus.mfx_data !== 32'h0000_1234) begin
            bad++; $display("FAIL mfhi got=%h want=00001234", bus.mfx_data); end
        drive(4'd8, 1'b1, 32'hABCD_0000, 32'h0, 1'b0);
        tick();
        drive(4'd6, 1'b1, 32'h0, 32'h0, 1'b0);
        total++; if (bus.mfx_data !== 32'hABCD_0000) begin
            bad++; $display("FAIL mflo got=%h want=abcd0000", bus.mfx_data); end
        drive(4'd6, 1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (bus.mfx_data !== 32'd0) begin bad++; $display("FAIL mfx_invalid got=%h want=0", bus.mfx_data); end
        drive(4'd1, 1'b1, 32'd3, 32'd4, 1'b0);
        tick();
        drive(4'd8, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tick();
        drive(4'd6, 1'b1, 32'h0, 32'h0, 1'b0);
        total++; if (bus.lo !== 32'hABCD_0000 || bus.mfx_data !== 32'hABCD_0000) begin
            bad++; $display("FAIL mtlo_busy got=%h/%h want=abcd0000", bus.lo, bus.mfx_data); end
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle(n);
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
            bad++; $display("FAIL mtx_mult got=%h_%h want=00000000_0000000c", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid();
        int n;
        drive(4'd3, 1'b1, 32'd100, 32'd7, 1'b0);
        tick();
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick(); tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", bus.busy); end
        reset = 1'b0;
        #1;
        model_reset();
        total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++; $display("FAIL rmid_async got=%b %h_%h want=0 0_0", bus.busy, bus.hi, bus.lo); end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++; $display("FAIL rmid_release got=%b %h_%h want=0 0_0", bus.busy, bus.hi, bus.lo); end
        for (int i = 0; i < DIV_CYC + 2; i++) tick();
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++; $display("FAIL rmid_nocommit got=%h_%h want=0_0", bus.hi, bus.lo); end
        wait_idle(n);
    endtask

    task automatic test_random();
        logic [31:0] rs, rt;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: rt = 32'd0;
                1: rt = 32'hFFFF_FFFF;
                2: rt = $urandom_range(1, 9);
                default: rt = $urandom;
            endcase
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), rs, rt,
                  1'($urandom_range(0, 1)));
            total++; if (bus.busy !== exp_busy()) begin
                bad++; $display("FAIL rnd_busy i=%0d got=%b want=%b", i, bus.busy, exp_busy()); end
            total++; if (bus.stall !== exp_stall()) begin
                bad++; $display("FAIL rnd_stall i=%0d got=%b want=%b", i, bus.stall, exp_stall()); end
            total++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin
                bad++; $display("FAIL rnd_hilo i=%0d got=%h_%h want=%h_%h", i, bus.hi, bus.lo, m_hi, m_lo); end
            total++; if (bus.mfx_data !== exp_mfx()) begin
                bad++; $display("FAIL rnd_mfx i=%0d got=%h want=%h", i, bus.mfx_data, exp_mfx()); end
            tick();
        end
        drive(4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_stall();
        test_back_to_back();
        test_mtx();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
